// File: rtl/max_pool_2x2_pkg.sv
// Shared CNN constants: default sample width and the 2x2 / stride-2 pooling
// geometry, plus a width helper used by the pooling stage.
package max_pool_2x2_pkg;

  localparam int CNN_DATA_W  = 32;
  localparam int POOL_WIN    = 2;
  localparam int POOL_STRIDE = 2;

  // Index width for a counter or address over n items, never below 1 bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/max_pool_2x2_max2.sv
// Signed two-input maximum. Ties return the common value.
module max2 #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);

  assign y = (a >= b) ? a : b;

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2, stride-2 max pooling over a raster-order feature map.
// Even columns park a sample in h_hold; odd columns fold it into a horizontal
// max. Even rows stash that pair max in a half-width line buffer, odd rows
// combine it with the buffered value and emit one pooled sample.
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int COL_W = idx_w(IMG_W);
  localparam int ROW_W = idx_w(IMG_H);
  localparam int LB_N  = IMG_W / POOL_WIN;
  localparam int LB_AW = idx_w(LB_N);
  // Depth rounded up to a power of two so every address value is in range.
  localparam int LB_D  = 2 ** LB_AW;

  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic signed [DATA_W-1:0] h_hold_q;
  logic signed [DATA_W-1:0] d_out_q;
  logic                     out_valid_q;
  logic                     frame_done_q;

  logic signed [DATA_W-1:0] lb_q [0:LB_D-1];
  logic [LB_AW-1:0]         lb_addr;
  logic signed [DATA_W-1:0] lb_rd;

  logic signed [DATA_W-1:0] din_s;
  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] vmax;

  logic last_col, last_row;
  logic odd_col, odd_row;
  logic lb_we, emit;

  assign din_s    = signed'(d_in);
  assign last_col = (col_q == COL_W'(IMG_W - 1));
  assign last_row = (row_q == ROW_W'(IMG_H - 1));
  assign odd_col  = col_q[0];
  assign odd_row  = row_q[0];
  assign lb_addr  = LB_AW'(col_q >> 1);
  assign lb_rd    = lb_q[lb_addr];

  assign lb_we = in_valid && odd_col && !odd_row;
  assign emit  = in_valid && odd_col && odd_row;

  max2 #(.DATA_W(DATA_W)) u_hmax (
    .a (h_hold_q),
    .b (din_s),
    .y (hmax)
  );

  max2 #(.DATA_W(DATA_W)) u_vmax (
    .a (hmax),
    .b (lb_rd),
    .y (vmax)
  );

  // Raster position of the next accepted sample; wraps at end of frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position, horizontal hold and pooled output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      h_hold_q     <= '0;
      d_out_q      <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= emit;
      frame_done_q <= emit && last_col && last_row;
      if (in_valid && !odd_col) begin
        h_hold_q <= din_s;
      end
      if (emit) begin
        d_out_q <= vmax;
      end
    end
  end

  // Line buffer: pair maxima from the even row, consumed on the odd row.
  // No reset needed since each entry is written before it is read.
  always_ff @(posedge clk) begin
    if (!rst && lb_we) begin
      lb_q[lb_addr] <= hmax;
    end
  end

  assign d_out      = d_out_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: a 4x2 instance driven from a vector table plus a
// mid-frame reset sequence, and a 4x4 instance for back-to-back frames.
module tb_max_pool_2x2;

  typedef struct packed {
    logic [0:7][31:0] s;
    logic [31:0]      e0;
    logic [31:0]      e1;
    logic             gaps;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        fd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_iv = 1'b0, b_iv = 1'b0;
  logic [31:0] a_di = '0,   b_di = '0;
  logic [31:0] a_do, b_do;
  logic        a_ov, b_ov, a_fd, b_fd;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic rst_e = 1'b1;

  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] a_last = '0, b_last = '0;

  vec_t tbl [6];

  max_pool_2x2 #(.DATA_W(32), .IMG_W(4), .IMG_H(2)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (a_iv),
    .d_in       (a_di),
    .d_out      (a_do),
    .out_valid  (a_ov),
    .frame_done (a_fd)
  );

  max_pool_2x2 #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_iv),
    .d_in       (b_di),
    .d_out      (b_do),
    .out_valid  (b_ov),
    .frame_done (b_fd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_e <= rst;
  end

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d",
               name, $signed(act), act, $signed(req), req, cyc);
    end
  endtask

  function automatic logic [31:0] smax(input logic [31:0] x, input logic [31:0] y);
    return ($signed(x) >= $signed(y)) ? x : y;
  endfunction

  // Output monitor, 4x2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_e) begin
      check("a_reset_dout", a_do === 32'd0, a_do, 32'd0);
      check("a_reset_ov",   a_ov === 1'b0 && a_fd === 1'b0, {30'd0, a_ov, a_fd}, 32'd0);
      a_last = 32'd0;
    end else if (a_ov === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_unexpected_out", 1'b0, a_do, 32'd0);
      end else begin
        e = qa.pop_front();
        check("a_dout",    a_do === e.d, a_do, e.d);
        check("a_fdone",   a_fd === e.fd, {31'd0, a_fd}, {31'd0, e.fd});
        check("a_latency", cyc == e.cyc, cyc, e.cyc);
      end
      a_last = a_do;
    end else begin
      check("a_hold", a_do === a_last && a_fd === 1'b0, a_do, a_last);
    end
  end

  // Output monitor, 4x4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_e) begin
      check("b_reset_dout", b_do === 32'd0, b_do, 32'd0);
      check("b_reset_ov",   b_ov === 1'b0 && b_fd === 1'b0, {30'd0, b_ov, b_fd}, 32'd0);
      b_last = 32'd0;
    end else if (b_ov === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_unexpected_out", 1'b0, b_do, 32'd0);
      end else begin
        e = qb.pop_front();
        check("b_dout",    b_do === e.d, b_do, e.d);
        check("b_fdone",   b_fd === e.fd, {31'd0, b_fd}, {31'd0, e.fd});
        check("b_latency", cyc == e.cyc, cyc, e.cyc);
      end
      b_last = b_do;
    end else begin
      check("b_hold", b_do === b_last && b_fd === 1'b0, b_do, b_last);
    end
  end

  // One 4x2 frame; outputs expected after samples 5 and 7 (odd row, odd col).
  task automatic drive_a(input vec_t v);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (v.gaps && i != 0) begin
        a_iv = 1'b0;
        a_di = $urandom;
        @(posedge clk); #1;
      end
      a_iv = 1'b1;
      a_di = v.s[i];
      if (i == 5 || i == 7) begin
        e.d   = (i == 5) ? v.e0 : v.e1;
        e.fd  = (i == 7);
        e.cyc = cyc + 1;
        qa.push_back(e);
      end
      @(posedge clk); #1;
    end
    a_iv = 1'b0;
  endtask

  // One 4x4 frame; expected window maxima derived from the full frame.
  task automatic drive_b(input logic [31:0] s [16]);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      b_iv = 1'b1;
      b_di = s[i];
      if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
        e.d   = smax(smax(s[i-5], s[i-4]), smax(s[i-1], s[i]));
        e.fd  = (i == 15);
        e.cyc = cyc + 1;
        qb.push_back(e);
      end
      @(posedge clk); #1;
    end
    b_iv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] fr [16];
    int          budget;

    tbl[0] = '{s: {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
               e0: 32'd6, e1: 32'd8, gaps: 1'b0};
    tbl[1] = '{s: {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
               e0: 32'd6, e1: 32'd8, gaps: 1'b1};
    tbl[2] = '{s: {32'hFFFFFFFB, 32'hFFFFFFFD, 32'h7FFFFFFF, 32'd0,
                   32'hFFFFFFF7, 32'hFFFFFFFC, 32'd1, 32'd2},
               e0: 32'hFFFFFFFD, e1: 32'h7FFFFFFF, gaps: 1'b0};
    tbl[3] = '{s: {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
               e0: 32'd8, e1: 32'd6, gaps: 1'b1};
    tbl[4] = '{s: {32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5},
               e0: 32'd5, e1: 32'd5, gaps: 1'b0};
    tbl[5] = '{s: {32'h80000000, 32'h80000000, 32'd0, 32'hFFFFFFFF,
                   32'h80000000, 32'h80000000, 32'hFFFFFFFE, 32'hFFFFFFFD},
               e0: 32'h80000000, e1: 32'd0, gaps: 1'b0};

    // Hold reset, then release.
    idle(3);
    rst = 1'b0;
    idle(2);

    // Table vectors, back to back where gaps are off.
    for (int k = 0; k < 6; k++) begin
      drive_a(tbl[k]);
    end
    idle(3);

    // Mid-frame reset: five samples of garbage, one reset cycle, clean frame.
    for (int i = 0; i < 5; i++) begin
      a_iv = 1'b1;
      a_di = 32'd100 + 32'(i);
      @(posedge clk); #1;
    end
    a_iv = 1'b0;
    rst  = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
    drive_a(tbl[0]);
    idle(3);

    // Two back-to-back 4x4 frames of 7, then a random frame.
    for (int i = 0; i < 16; i++) fr[i] = 32'd7;
    drive_b(fr);
    drive_b(fr);
    for (int i = 0; i < 16; i++) fr[i] = $urandom;
    drive_b(fr);

    budget = 0;
    while ((qa.size() != 0 || qb.size() != 0) && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    idle(2);
    check("a_drained", qa.size() == 0, qa.size(), 32'd0);
    check("b_drained", qb.size() == 0, qb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning sample width in bits, two's-complement signed.
REQ-002 The block SHALL have parameter IMG_W, default 8, meaning feature-map width in samples; it must be even and at least 2.
REQ-003 The block SHALL have parameter IMG_H, default 8, meaning feature-map height in rows; it must be even and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: d_in carries a sample this cycle.
REQ-007 The block SHALL have port d_in, input, DATA_W bits: ReLU-stage output sample, raster order, row-major.
REQ-008 The block SHALL have port d_out, output, DATA_W bits: pooled 2x2 maximum.
REQ-009 The block SHALL have port out_valid, output, 1 bit: d_out is valid this cycle, single-cycle pulse per pooled sample.
REQ-010 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse coincident with the last pooled output of a frame.

Function
REQ-011 The block SHALL count accepted samples only; a cycle with in_valid=0 SHALL change no state except clearing the output pulses. Gaps of any length are legal, and there is no backpressure.
REQ-012 Column counter col SHALL run 0..IMG_W-1 and row counter row SHALL run 0..IMG_H-1. Both wrap to 0 after the last accepted sample of a frame, so the next sample starts a new frame.
REQ-013 On an even col, the block SHALL hold the sample in register h_hold.
REQ-014 On an odd col, the block SHALL form hmax = signed max(h_hold, d_in).
REQ-015 On an even row with odd col, the block SHALL write hmax to line buffer entry col>>1; the buffer holds IMG_W/2 entries of DATA_W bits.
REQ-016 On an odd row with odd col, the block SHALL compute signed max(hmax, buffer[col>>1]), register it to d_out, and assert out_valid the next cycle (latency 1 cycle from the fourth window sample).
REQ-017 Ties SHALL produce the equal value, and comparison SHALL be signed even though upstream data is non-negative.
REQ-018 d_out SHALL hold its last value when out_valid=0.
REQ-019 frame_done SHALL assert with out_valid when that output came from row=IMG_H-1, col=IMG_W-1.
REQ-020 The block SHALL produce exactly (IMG_W/2)*(IMG_H/2) outputs per frame, in raster order of the pooled map.
REQ-021 Back-to-back frames with in_valid held high SHALL have no dead cycle between them.

Reset
REQ-022 While rst=1 at a rising clk edge, the block SHALL clear col, row, h_hold, d_out, out_valid and frame_done to 0, and SHALL ignore in_valid.
REQ-023 Line buffer contents need not be reset; each entry is always written on an even row before it is read on the following odd row.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; the first sample accepted after rst deasserts is row 0, col 0.

Structure
REQ-025 DATA_W default and pooling constants (window 2, stride 2) SHALL live in the shared CNN parameter package/include used by all stages.
REQ-026 Signed two-input maximum SHALL be a reusable combinational sub-module max2 (ports a, b, y; parameter DATA_W), instantiated twice.
REQ-027 The line buffer SHALL be an inferred register array (distributed RAM) with one write and one read port.

Verification
REQ-028 With IMG_W=4, IMG_H=2, continuous in_valid, feed d_in=1..8. The bench SHALL see out_valid twice, with d_out=6 then 8; frame_done SHALL be high with the 8.
REQ-029 Feed the same data with in_valid toggling every cycle. The bench SHALL see identical d_out values, each one cycle after its 4th window sample.
REQ-030 Use window values -5, -3, -9, -4 (signed) on 2x2, then 32'h7FFFFFFF in any position. The bench SHALL see d_out=-3, then 32'h7FFFFFFF.
REQ-031 Assert rst for one cycle after 5 samples of a 4x2 frame, then feed 1..8. The bench SHALL see exactly two outputs, 6 and 8, and no output from the discarded partial data.
REQ-032 Run two consecutive 4x4 frames of value 7 with in_valid continuously high. The bench SHALL see 8 outputs of 7 and frame_done on the 4th and 8th outputs only.
